// File: rtl/fetch_stage.sv
// Purpose : instruction fetch stage; drives an 8-bit instruction memory and fills the IF/ID register.
// Latency : request issued in cycle N is visible on IF/ID in cycle N+2; one instruction per cycle sustained.
// Backpressure: stall holds IF/ID and blocks new requests; a response already in flight lands in a 1-entry skid.
// Ports:
//   clk, rst (sync, active-low)        clock and reset
//   stall                              downstream not accepting IF/ID
//   jump_en, jump_target               redirect from decode; wins over stall
//   imem_en, imem_addr, imem_rdata     instruction memory (data one cycle after imem_en)
//   if_id_valid/instr/pc/opcode        IF/ID pipeline register
//   halted, flush_cnt                  HALT status, saturating count of accepted redirects
module fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  output logic       imem_en,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic       if_id_valid,
  output logic [7:0] if_id_instr,
  output logic [7:0] if_id_pc,
  output logic [1:0] if_id_opcode,
  output logic       halted,
  output logic [7:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b10;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic       r_pend;
  logic [7:0] r_pend_pc;
  logic       r_skid_vld;
  logic [7:0] r_skid_dat;
  logic [7:0] r_skid_pc;
  logic       r_if_id_valid;
  logic [7:0] r_if_id_instr;
  logic [7:0] r_if_id_pc;
  logic       r_halted;
  logic [7:0] r_flush_cnt;

  logic       w_jump;
  logic       w_imem_en;
  logic       w_resp;
  logic       w_to_skid;
  logic       w_load_skid;
  logic       w_load_resp;
  logic       w_load;
  logic [7:0] w_load_dat;
  logic [7:0] w_load_pc;
  logic       w_halt_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath steering
  always_comb begin
    w_state_nxt = r_state;
    // Redirects are ignored during the single post-reset init cycle.
    w_jump      = jump_en && (r_state != S_INIT);
    // rst is included so no request leaks out while reset is asserted.
    w_imem_en   = rst && (r_state == S_RUN) && !stall && !jump_en;
    // Responses only count in S_RUN; in S_HALT or on a redirect they are dropped.
    w_resp      = r_pend && (r_state == S_RUN) && !w_jump;
    w_to_skid   = w_resp && stall;
    // A skid entry implies the previous cycle was stalled, so no response can coincide.
    w_load_skid = (r_state == S_RUN) && !w_jump && !stall && r_skid_vld;
    w_load_resp = w_resp && !stall && !r_skid_vld;
    w_load      = w_load_skid || w_load_resp;
    w_load_dat  = r_skid_vld ? r_skid_dat : imem_rdata;
    w_load_pc   = r_skid_vld ? r_skid_pc  : r_pend_pc;
    w_halt_hit  = w_load && (w_load_dat[7:6] == OP_HALT);

    case (r_state)
      S_INIT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_jump) begin
          w_state_nxt = S_RUN;
        end else if (w_halt_hit) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (w_jump) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_pc     <= 8'h00;
      r_skid_vld    <= 1'b0;
      r_skid_dat    <= 8'h00;
      r_skid_pc     <= 8'h00;
      r_if_id_valid <= 1'b0;
      r_if_id_instr <= 8'h00;
      r_if_id_pc    <= 8'h00;
      r_halted      <= 1'b0;
      r_flush_cnt   <= 8'h00;
    end else if (w_jump) begin
      r_pc          <= jump_target;
      r_pend        <= 1'b0;
      r_skid_vld    <= 1'b0;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
      if (r_flush_cnt != 8'hFF) begin
        r_flush_cnt <= r_flush_cnt + 8'd1;
      end
    end else begin
      r_pend <= w_imem_en;
      if (w_imem_en) begin
        r_pc      <= r_pc + 8'd1;
        r_pend_pc <= r_pc;
      end

      if (w_to_skid) begin
        r_skid_vld <= 1'b1;
        r_skid_dat <= imem_rdata;
        r_skid_pc  <= r_pend_pc;
      end else if (w_load_skid) begin
        r_skid_vld <= 1'b0;
      end

      // Without a new instruction, an unstalled IF/ID drains to a bubble but keeps its data.
      if (w_load) begin
        r_if_id_valid <= 1'b1;
        r_if_id_instr <= w_load_dat;
        r_if_id_pc    <= w_load_pc;
      end else if (!stall) begin
        r_if_id_valid <= 1'b0;
      end

      if (w_halt_hit) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign imem_en      = w_imem_en;
  assign imem_addr    = r_pc;
  assign if_id_valid  = r_if_id_valid;
  assign if_id_instr  = r_if_id_instr;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_opcode = r_if_id_instr[7:6];
  assign halted       = r_halted;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : self-checking bench for fetch_stage with a queue scoreboard of delivered instructions.
// Latency : memory model returns data one cycle after imem_en, as the stage expects.
// Backpressure: stall is driven directly by the stimulus sequence.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       if_id_valid;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc;
  logic [1:0] if_id_opcode;
  logic       halted;
  logic [7:0] flush_cnt;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_opcode (if_id_opcode),
    .halted       (halted),
    .flush_cnt    (flush_cnt)
  );

  // Instruction memory: synchronous read, data valid the cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // Default contents: opcode 01, low bits = address+1 (addr 0..2 -> 0x41,0x42,0x43).
  function automatic logic [7:0] memval(input logic [7:0] a);
    logic [7:0] t;
    t = a + 8'd1;
    return 8'h40 | (t & 8'h3F);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [7:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // One cycle: inputs change 1 time unit after the edge, checks follow at +3.
  task automatic cyc(input logic r, input logic s, input logic j, input logic [7:0] t);
    @(posedge clk);
    #1;
    rst         = r;
    stall       = s;
    jump_en     = j;
    jump_target = t;
    #2;
  endtask

  // Monitor: every instruction accepted downstream (valid with no stall) is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (if_id_valid === 1'b1 && stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h instr %h, expected no instruction", if_id_pc, if_id_instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk8("sb_pc", if_id_pc, mon_e[15:8]);
          chk8("sb_instr", if_id_instr, mon_e[7:0]);
          chk8("sb_opcode", {6'd0, if_id_opcode}, {6'd0, mon_e[7:6]});
        end
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = memval(8'(i));

    // Reset
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk1("rst_imem_en", imem_en, 1'b0);
    chk8("rst_imem_addr", imem_addr, 8'h00);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk8("rst_instr", if_id_instr, 8'h00);
    chk8("rst_pc", if_id_pc, 8'h00);
    chk1("rst_halted", halted, 1'b0);
    chk8("rst_flush", flush_cnt, 8'h00);
    cyc(0, 0, 0, 8'h00);

    // Streaming; a jump during S_INIT must be ignored
    push(8'h00, 8'h41); push(8'h01, 8'h42); push(8'h02, 8'h43); push(8'h03, 8'h44);
    push(8'h04, 8'h45); push(8'h05, 8'h46); push(8'h06, 8'h47);
    cyc(1, 0, 1, 8'h55);                                  // C0 S_INIT
    chk1("init_imem_en", imem_en, 1'b0);
    cyc(1, 0, 0, 8'h00);                                  // C1
    chk1("c1_imem_en", imem_en, 1'b1);
    chk8("c1_addr_init_jump_ignored", imem_addr, 8'h00);
    chk8("c1_flush", flush_cnt, 8'h00);
    cyc(1, 0, 0, 8'h00);                                  // C2
    chk1("c2_valid", if_id_valid, 1'b0);
    chk8("c2_addr", imem_addr, 8'h01);
    cyc(1, 0, 0, 8'h00);                                  // C3
    chk1("c3_valid_first", if_id_valid, 1'b1);
    cyc(1, 0, 0, 8'h00);                                  // C4
    cyc(1, 0, 0, 8'h00);                                  // C5
    cyc(1, 0, 0, 8'h00);                                  // C6
    chk8("c6_addr", imem_addr, 8'h05);

    // Stall two cycles with addr 5 in flight
    cyc(1, 1, 0, 8'h00);                                  // C7
    chk1("stall_imem_en", imem_en, 1'b0);
    cyc(1, 1, 0, 8'h00);                                  // C8
    chk1("stall_hold_valid", if_id_valid, 1'b1);
    chk8("stall_hold_pc", if_id_pc, 8'h04);
    chk8("stall_hold_addr", imem_addr, 8'h06);
    cyc(1, 0, 0, 8'h00);                                  // C9
    cyc(1, 0, 0, 8'h00);                                  // C10
    cyc(1, 0, 0, 8'h00);                                  // C11

    // Jump while stalled with a full skid
    cyc(1, 1, 0, 8'h00);                                  // C12
    cyc(1, 1, 1, 8'h20);                                  // C13
    chk1("jmp_imem_en", imem_en, 1'b0);
    cyc(1, 1, 0, 8'h00);                                  // C14
    chk1("jmp_valid", if_id_valid, 1'b0);
    chk8("jmp_flush", flush_cnt, 8'h01);
    chk8("jmp_addr", imem_addr, 8'h20);
    chk1("jmp_stall_imem_en", imem_en, 1'b0);
    push(8'h20, 8'h61);
    cyc(1, 0, 0, 8'h00);                                  // C15
    chk1("jmp_resume_en", imem_en, 1'b1);
    chk8("jmp_resume_addr", imem_addr, 8'h20);
    cyc(1, 0, 0, 8'h00);                                  // C16
    chk1("jmp_skid_empty", if_id_valid, 1'b0);

    // HALT at address 3
    mem[3] = 8'h80;
    cyc(1, 0, 1, 8'h00);                                  // C17
    chk1("jmp2_imem_en", imem_en, 1'b0);
    cyc(1, 0, 0, 8'h00);                                  // C18
    chk8("jmp2_flush", flush_cnt, 8'h02);
    chk1("jmp2_valid", if_id_valid, 1'b0);
    chk8("jmp2_addr", imem_addr, 8'h00);
    push(8'h00, 8'h41); push(8'h01, 8'h42); push(8'h02, 8'h43); push(8'h03, 8'h80);
    cyc(1, 0, 0, 8'h00);                                  // C19
    cyc(1, 0, 0, 8'h00);                                  // C20
    cyc(1, 0, 0, 8'h00);                                  // C21
    cyc(1, 0, 0, 8'h00);                                  // C22
    cyc(1, 1, 0, 8'h00);                                  // C23
    chk1("halt_set", halted, 1'b1);
    chk8("halt_instr", if_id_instr, 8'h80);
    chk1("halt_imem_en", imem_en, 1'b0);
    cyc(1, 1, 0, 8'h00);                                  // C24
    chk1("halt_hold_valid", if_id_valid, 1'b1);
    chk8("halt_pc_hold", imem_addr, 8'h05);
    cyc(1, 0, 0, 8'h00);                                  // C25
    chk1("halt_nostall_en", imem_en, 1'b0);
    cyc(1, 0, 0, 8'h00);                                  // C26
    chk1("halt_drop_valid", if_id_valid, 1'b0);
    chk1("halt_still", halted, 1'b1);
    chk1("halt_en_off", imem_en, 1'b0);
    mem[3] = 8'h44;
    cyc(1, 0, 1, 8'h00);                                  // C27
    cyc(1, 0, 0, 8'h00);                                  // C28
    chk1("unhalt", halted, 1'b0);
    chk1("unhalt_en", imem_en, 1'b1);
    chk8("unhalt_addr", imem_addr, 8'h00);
    chk8("unhalt_flush", flush_cnt, 8'h03);
    push(8'h00, 8'h41); push(8'h01, 8'h42); push(8'h02, 8'h43);
    cyc(1, 0, 0, 8'h00);                                  // C29
    cyc(1, 0, 0, 8'h00);                                  // C30
    cyc(1, 0, 0, 8'h00);                                  // C31

    // Reset mid-stream with a response pending
    cyc(0, 0, 0, 8'h00);                                  // C32
    chk1("mrst_en", imem_en, 1'b0);
    cyc(0, 0, 0, 8'h00);                                  // C33
    chk1("mrst_valid", if_id_valid, 1'b0);
    chk8("mrst_addr", imem_addr, 8'h00);
    chk1("mrst_en2", imem_en, 1'b0);
    chk8("mrst_flush", flush_cnt, 8'h00);
    cyc(1, 0, 0, 8'h00);                                  // C34 S_INIT
    chk1("mrst_init_en", imem_en, 1'b0);
    chk8("mrst_init_addr", imem_addr, 8'h00);

    // PC wrap
    cyc(1, 0, 1, 8'hFD);                                  // C35
    push(8'hFD, 8'h7E); push(8'hFE, 8'h7F); push(8'hFF, 8'h40); push(8'h00, 8'h41);
    cyc(1, 0, 0, 8'h00);                                  // C36
    chk8("wrap_fd", imem_addr, 8'hFD);
    chk8("wrap_flush", flush_cnt, 8'h01);
    cyc(1, 0, 0, 8'h00);                                  // C37
    cyc(1, 0, 0, 8'h00);                                  // C38
    chk8("wrap_ff", imem_addr, 8'hFF);
    cyc(1, 0, 0, 8'h00);                                  // C39
    chk8("wrap_00", imem_addr, 8'h00);
    cyc(1, 0, 0, 8'h00);                                  // C40
    cyc(1, 0, 0, 8'h00);                                  // C41

    // flush_cnt saturation
    for (int k = 0; k < 253; k++) cyc(1, 1, 1, 8'h10);
    cyc(1, 1, 0, 8'h00);
    chk8("sat_fe", flush_cnt, 8'hFE);
    for (int k = 0; k < 10; k++) cyc(1, 1, 1, 8'h10);
    cyc(1, 1, 0, 8'h00);
    chk8("sat_ff", flush_cnt, 8'hFF);
    chk1("sat_valid", if_id_valid, 1'b0);
    cyc(1, 0, 0, 8'h00);
    chk1("sat_resume_en", imem_en, 1'b1);
    chk8("sat_resume_addr", imem_addr, 8'h10);

    chk8("sb_drain", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, address loaded into the PC on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (rst=0 resets on next clk edge).
REQ-004 stall  input  1  downstream not accepting; IF/ID register SHALL hold.
REQ-005 jump_en  input  1  redirect request from decode (JumpPC); priority over stall.
REQ-006 jump_target  input  8  redirect address.
REQ-007 imem_en  output  1  instruction memory read request, combinational.
REQ-008 imem_addr  output  8  read address, equal to pc_q.
REQ-009 imem_rdata  input  8  read data, valid exactly one cycle after imem_en=1.
REQ-010 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-011 if_id_instr  output  8  fetched instruction.
REQ-012 if_id_pc  output  8  address of if_id_instr.
REQ-013 if_id_opcode  output  2  if_id_instr[7:6], drives decode control opcode.
REQ-014 halted  output  1  fetch stopped by HALT instruction.
REQ-015 flush_cnt  output  8  count of accepted redirects, saturating.

Function
REQ-016 FSM states: S_INIT, S_RUN, S_HALT; S_INIT lasts exactly one cycle after reset release, then S_RUN.
REQ-017 imem_en SHALL be 1 iff state=S_RUN and stall=0 and jump_en=0; never in S_INIT or S_HALT.
REQ-018 On imem_en=1: pc_q <= pc_q+1 (8-bit, 8'hFF wraps to 8'h00); pend <= 1; pend_pc <= pc_q; otherwise pend <= 0.
REQ-019 Response (pend=1) with stall=0 and skid empty: if_id_instr <= imem_rdata, if_id_pc <= pend_pc, if_id_valid <= 1.
REQ-020 Response with stall=1: captured into 1-entry skid buffer (data, pc); IF/ID holds.
REQ-021 stall=0 with skid valid: IF/ID <= skid contents, skid cleared; no response can coincide (no request during the stall cycle).
REQ-022 stall=0, no skid, no response: if_id_valid <= 0 (bubble); if_id_instr/if_id_pc hold value.
REQ-023 stall=1, no response: all IF/ID fields, skid, pc_q hold.
REQ-024 jump_en=1 (any state except S_INIT, regardless of stall): pc_q <= jump_target; pend, skid, if_id_valid <= 0; response arriving same cycle discarded; state <= S_RUN; halted <= 0; flush_cnt += 1, saturating at 8'hFF.
REQ-025 jump_en in S_INIT SHALL be ignored.
REQ-026 HALT = opcode 2'b10; when a HALT instruction is written into IF/ID (from response or skid): state <= S_HALT, halted <= 1 same edge.
REQ-027 In S_HALT: no requests; in-flight response discarded, not written to skid or IF/ID; pc_q holds; HALT instruction stays in IF/ID until stall=0, then if_id_valid <= 0.
REQ-028 S_HALT exits only via jump_en or reset.
REQ-029 Latency: instruction at address A, issued cycle N, visible on IF/ID outputs at cycle N+2 when stall=0 throughout.
REQ-030 One instruction per cycle sustained throughput when stall=0 and no jumps.

Reset
REQ-031 rst=0 at clk edge: pc_q=RESET_PC, state=S_INIT, pend=0, skid empty, if_id_valid=0, if_id_instr=8'h00, if_id_pc=8'h00, halted=0, flush_cnt=0.
REQ-032 imem_en SHALL be 0 while rst=0 and during S_INIT.
REQ-033 Reset mid-operation (pending response, full skid, S_HALT) SHALL discard everything and restore REQ-031 values.

Verification
REQ-034 Streaming: reset release, memory holds 0x41,0x42,0x43 at 0..2 -> if_id_instr 0x41/0x42/0x43 with if_id_pc 0/1/2 on consecutive cycles, first at 3rd cycle after S_INIT.
REQ-035 Stall with in-flight response: stall=1 two cycles while fetch of addr 5 pending -> addr 5 held in skid, delivered on first stall=0 cycle, then addr 6 follows; no instruction lost or duplicated.
REQ-036 Jump during stall: stall=1, skid full, jump_en=1, jump_target=0x20 -> next cycle if_id_valid=0, skid empty, imem_addr=0x20 once stall drops, flush_cnt=1.
REQ-037 HALT: instruction 0x80 at addr 3 -> halted=1 when 0x80 enters IF/ID, addr 4 response discarded, imem_en stays 0; jump_en to 0x00 -> halted=0, fetch resumes at 0.
REQ-038 Wrap/saturation: pc_q=0xFF issues then 0x00; 256 jumps -> flush_cnt=0xFF.
REQ-039 Reset mid-stream with pend=1 -> if_id_valid=0, imem_addr=RESET_PC, imem_en=0 for reset and S_INIT cycles.
